// File: rtl/traffic_lane.sv
// rtl/traffic_lane.sv - multi-car lane generator: equally spaced cars, shared tick, frog overlap detect
module traffic_lane #(
  parameter int NUM_CARS  = 4,
  parameter int X_W       = 10,
  parameter int H_DISPLAY = 640,
  parameter int CAR_W     = 32,
  parameter int SPACING   = 160,
  parameter int DIV_W     = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      direction,
  input  logic [1:0]                step,
  input  logic [DIV_W-1:0]          period_in,
  input  logic                      period_load,
  input  logic [X_W-1:0]            start_x,
  input  logic [9:0]                start_y,
  input  logic [X_W-1:0]            probe_x,
  input  logic [5:0]                probe_w,
  output logic [NUM_CARS*X_W-1:0]   car_x_bus,
  output logic [9:0]                lane_y,
  output logic                      move_tick,
  output logic                      hit
);

  // Span arithmetic needs room for probe_x + probe_w and x + CAR_W without overflow.
  localparam int EW = X_W + 7;
  localparam logic [X_W:0] H_EXT = (X_W+1)'(H_DISPLAY);

  logic [X_W-1:0]   car_x  [NUM_CARS];
  logic [X_W-1:0]   next_x [NUM_CARS];
  logic [X_W-1:0]   rst_x  [NUM_CARS];
  logic [DIV_W-1:0] period_reg;
  logic [DIV_W-1:0] cnt;
  logic             tick_now;
  logic             hit_now;

  always_comb begin
    tick_now = enable && !period_load && (period_reg != '0) &&
               (cnt == period_reg - DIV_W'(1));
  end

  always_comb begin : reset_positions
    logic [X_W-1:0] base;
    base = (start_x >= X_W'(H_DISPLAY)) ? '0 : start_x;
    for (int i = 0; i < NUM_CARS; i++) begin
      rst_x[i] = X_W'((32'(base) + 32'(i) * 32'(SPACING)) % 32'(H_DISPLAY));
    end
  end

  always_comb begin : advance
    logic [X_W:0] n;
    logic [X_W:0] step_ext;
    step_ext = (X_W+1)'(step);
    for (int i = 0; i < NUM_CARS; i++) begin
      n = {1'b0, car_x[i]} + step_ext;
      if (!direction) begin
        next_x[i] = (n >= H_EXT) ? X_W'(n - H_EXT) : X_W'(n);
      end else if (car_x[i] < X_W'(step)) begin
        next_x[i] = X_W'({1'b0, car_x[i]} + H_EXT - step_ext);
      end else begin
        next_x[i] = car_x[i] - X_W'(step);
      end
    end
  end

  // A car whose right edge passes H_DISPLAY also occupies [0, x+CAR_W-H_DISPLAY).
  always_comb begin : overlap
    logic [EW-1:0] p_lo;
    logic [EW-1:0] p_hi;
    logic [EW-1:0] c_lo;
    logic [EW-1:0] c_hi;
    logic          main_ov;
    logic          wrap_ov;
    p_lo    = EW'(probe_x);
    p_hi    = EW'(probe_x) + EW'(probe_w);
    hit_now = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      c_lo    = EW'(car_x[i]);
      c_hi    = EW'(car_x[i]) + EW'(CAR_W);
      main_ov = (p_lo < c_hi) && (c_lo < p_hi);
      wrap_ov = (c_hi > EW'(H_DISPLAY)) && (p_lo < c_hi - EW'(H_DISPLAY));
      if ((probe_w != '0) && (main_ov || wrap_ov)) begin
        hit_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x[i] <= rst_x[i];
      end
      lane_y     <= start_y;
      period_reg <= period_in;
      cnt        <= '0;
      move_tick  <= 1'b0;
      hit        <= 1'b0;
    end else begin
      hit       <= hit_now;
      move_tick <= tick_now;
      if (period_load) begin
        period_reg <= period_in;
        cnt        <= '0;
      end else if (enable && (period_reg != '0)) begin
        cnt <= tick_now ? '0 : cnt + DIV_W'(1);
      end
      if (tick_now) begin
        for (int i = 0; i < NUM_CARS; i++) begin
          car_x[i] <= next_x[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_bus
    assign car_x_bus[g*X_W +: X_W] = car_x[g];
  end

endmodule

// File: tb/tb_traffic_lane.sv
// tb/tb_traffic_lane.sv - self-checking bench for traffic_lane against a pixel-level lane model
module tb_traffic_lane;

  localparam int NC = 4;
  localparam int XW = 10;
  localparam int H  = 640;
  localparam int CW = 32;
  localparam int SP = 160;
  localparam int DW = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            direction;
  logic [1:0]      step;
  logic [DW-1:0]   period_in;
  logic            period_load;
  logic [XW-1:0]   start_x;
  logic [9:0]      start_y;
  logic [XW-1:0]   probe_x;
  logic [5:0]      probe_w;
  logic [NC*XW-1:0] car_x_bus;
  logic [9:0]      lane_y;
  logic            move_tick;
  logic            hit;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int mx [NC];
  int my, mper, mcnt, mmt, mhit;

  traffic_lane #(
    .NUM_CARS(NC), .X_W(XW), .H_DISPLAY(H), .CAR_W(CW), .SPACING(SP), .DIV_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .direction(direction), .step(step),
    .period_in(period_in), .period_load(period_load), .start_x(start_x), .start_y(start_y),
    .probe_x(probe_x), .probe_w(probe_w), .car_x_bus(car_x_bus), .lane_y(lane_y),
    .move_tick(move_tick), .hit(hit)
  );

  always #5 clk = ~clk;

  function automatic bit covers(int x, int q);
    return ((q >= x) && (q < x + CW)) || (q < x + CW - H);
  endfunction

  function automatic logic [NC*XW-1:0] exp_bus();
    logic [NC*XW-1:0] b;
    for (int i = 0; i < NC; i++) b[i*XW +: XW] = XW'(mx[i]);
    return b;
  endfunction

  function automatic int dut_car(int i);
    return int'(car_x_bus[i*XW +: XW]);
  endfunction

  // Lane model: advances on the same edge as the DUT using the inputs held across it.
  task automatic clk_cycle();
    int h;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NC; i++)
        mx[i] = (((int'(start_x) >= H) ? 0 : int'(start_x)) + i * SP) % H;
      my = start_y; mper = period_in; mcnt = 0; mmt = 0; mhit = 0;
    end else begin
      h = 0;
      for (int i = 0; i < NC; i++)
        for (int k = 0; k < int'(probe_w); k++)
          if (covers(mx[i], int'(probe_x) + k)) h = 1;
      mhit = h;
      mmt = 0;
      if (period_load) begin
        mper = period_in; mcnt = 0;
      end else if (enable && mper != 0) begin
        mcnt = mcnt + 1;
        if (mcnt == mper) begin
          mcnt = 0; mmt = 1;
          for (int i = 0; i < NC; i++)
            mx[i] = direction ? (mx[i] - step + H) % H : (mx[i] + step) % H;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(int sx, int sy, int per);
    reset = 1; enable = 0; period_load = 0;
    start_x = XW'(sx); start_y = 10'(sy); period_in = DW'(per);
    clk_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    int e1 [NC] = '{100, 260, 420, 580};
    int e2 [NC] = '{0, 160, 320, 480};
    probe_w = 0; probe_x = 0;
    do_reset(100, 200, 0);
    for (int i = 0; i < NC; i++) begin
      total_cnt++;
      if (dut_car(i) !== e1[i]) $display("FAIL reset_car%0d: got %0d want %0d", i, dut_car(i), e1[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (lane_y !== 10'd200) $display("FAIL reset_lane_y: got %0d want 200", lane_y); else pass_cnt++;
    total_cnt++;
    if (hit !== 1'b0 || move_tick !== 1'b0) $display("FAIL reset_flags: hit %b tick %b want 0 0", hit, move_tick);
    else pass_cnt++;
    do_reset(700, 5, 0);
    for (int i = 0; i < NC; i++) begin
      total_cnt++;
      if (dut_car(i) !== e2[i]) $display("FAIL reset_oob_car%0d: got %0d want %0d", i, dut_car(i), e2[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_move_right();
    do_reset(100, 33, 4);
    direction = 0; step = 2; enable = 1;
    for (int c = 1; c <= 12; c++) begin
      clk_cycle();
      total_cnt++;
      if (move_tick !== ((c % 4) == 0)) $display("FAIL right_tick c%0d: got %b want %b", c, move_tick, (c % 4) == 0);
      else pass_cnt++;
      total_cnt++;
      if (car_x_bus !== exp_bus()) $display("FAIL right_bus c%0d: got %h want %h", c, car_x_bus, exp_bus());
      else pass_cnt++;
      if (c == 4) begin
        total_cnt++;
        if (dut_car(3) !== 582) $display("FAIL right_car3: got %0d want 582", dut_car(3)); else pass_cnt++;
      end
    end
    do_reset(638, 33, 1);
    direction = 0; step = 2; enable = 1;
    clk_cycle();
    total_cnt++;
    if (dut_car(0) !== 0 || move_tick !== 1'b1) $display("FAIL right_wrap: got %0d tick %b want 0 tick 1", dut_car(0), move_tick);
    else pass_cnt++;
  endtask

  task automatic test_move_left();
    do_reset(1, 0, 1);
    direction = 1; step = 2; enable = 1;
    clk_cycle();
    total_cnt++;
    if (dut_car(0) !== 639) $display("FAIL left_wrap: got %0d want 639", dut_car(0)); else pass_cnt++;
    total_cnt++;
    if (car_x_bus !== exp_bus()) $display("FAIL left_bus: got %h want %h", car_x_bus, exp_bus()); else pass_cnt++;
    do_reset(2, 0, 1);
    direction = 1; step = 2; enable = 1;
    clk_cycle();
    total_cnt++;
    if (dut_car(0) !== 0) $display("FAIL left_zero: got %0d want 0", dut_car(0)); else pass_cnt++;
  endtask

  task automatic test_enable();
    logic [NC*XW-1:0] saved;
    do_reset(100, 0, 3);
    direction = 0; step = 1; enable = 1;
    repeat (4) clk_cycle();
    saved = car_x_bus;
    enable = 0;
    for (int c = 0; c < 10; c++) begin
      clk_cycle();
      total_cnt++;
      if (move_tick !== 1'b0 || car_x_bus !== saved)
        $display("FAIL frozen c%0d: tick %b bus %h want 0 %h", c, move_tick, car_x_bus, saved);
      else pass_cnt++;
    end
    enable = 1;
    clk_cycle();
    total_cnt++;
    if (move_tick !== 1'b0) $display("FAIL resume_early: got %b want 0", move_tick); else pass_cnt++;
    clk_cycle();
    total_cnt++;
    if (move_tick !== 1'b1 || car_x_bus !== exp_bus()) $display("FAIL resume_tick: tick %b bus %h want 1 %h", move_tick, car_x_bus, exp_bus());
    else pass_cnt++;
    period_in = 0; period_load = 1;
    clk_cycle();
    period_load = 0;
    saved = car_x_bus;
    for (int c = 0; c < 20; c++) begin
      clk_cycle();
      total_cnt++;
      if (move_tick !== 1'b0 || car_x_bus !== saved)
        $display("FAIL halted c%0d: tick %b bus %h want 0 %h", c, move_tick, car_x_bus, saved);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    do_reset(100, 0, 8);
    direction = 0; step = 1; enable = 1;
    repeat (5) clk_cycle();
    period_in = 3; period_load = 1;
    clk_cycle();
    period_load = 0;
    total_cnt++;
    if (move_tick !== 1'b0) $display("FAIL load_cycle_tick: got %b want 0", move_tick); else pass_cnt++;
    for (int c = 1; c <= 3; c++) begin
      clk_cycle();
      total_cnt++;
      if (move_tick !== (c == 3)) $display("FAIL load_after c%0d: got %b want %b", c, move_tick, c == 3);
      else pass_cnt++;
    end
    do_reset(100, 0, 4);
    enable = 1;
    repeat (3) clk_cycle();
    period_in = 4; period_load = 1;
    clk_cycle();
    period_load = 0;
    total_cnt++;
    if (move_tick !== 1'b0 || dut_car(0) !== 100) $display("FAIL load_terminal: tick %b car0 %0d want 0 100", move_tick, dut_car(0));
    else pass_cnt++;
  endtask

  task automatic test_hit();
    int px [4] = '{10, 22, 10, 635};
    int pw [4] = '{4, 4, 0, 10};
    int eh [4] = '{1, 0, 0, 1};
    do_reset(630, 0, 0);
    enable = 1;
    for (int t = 0; t < 4; t++) begin
      probe_x = XW'(px[t]); probe_w = 6'(pw[t]);
      clk_cycle();
      total_cnt++;
      if (hit !== eh[t][0] || hit !== mhit[0]) $display("FAIL hit_case%0d: got %b want %0d", t, hit, eh[t]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      direction   = 1'($urandom);
      step        = 2'($urandom);
      period_load = ($urandom_range(0, 19) == 0);
      period_in   = DW'($urandom_range(0, 6));
      start_x     = XW'($urandom_range(0, 1023));
      start_y     = 10'($urandom);
      probe_x     = XW'($urandom_range(0, 700));
      probe_w     = 6'($urandom);
      clk_cycle();
      total_cnt++;
      if (car_x_bus !== exp_bus()) $display("FAIL rnd_bus c%0d: got %h want %h", c, car_x_bus, exp_bus()); else pass_cnt++;
      total_cnt++;
      if (move_tick !== mmt[0]) $display("FAIL rnd_tick c%0d: got %b want %0d", c, move_tick, mmt); else pass_cnt++;
      total_cnt++;
      if (hit !== mhit[0]) $display("FAIL rnd_hit c%0d: got %b want %0d", c, hit, mhit); else pass_cnt++;
      total_cnt++;
      if (lane_y !== 10'(my)) $display("FAIL rnd_lane_y c%0d: got %0d want %0d", c, lane_y, my); else pass_cnt++;
    end
    reset = 0; period_load = 0;
  endtask

  initial begin
    reset = 1; enable = 0; direction = 0; step = 0; period_in = 0; period_load = 0;
    start_x = 0; start_y = 0; probe_x = 0; probe_w = 0;
    #2;
    test_reset();
    test_move_right();
    test_move_left();
    test_enable();
    test_load();
    test_hit();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
